display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_pkg.sv | 26 ++
 rtl/display_scan_ctrl_if.sv | 24 ++
 rtl/display_scan_ctrl_seg7_decode.sv | 11 +
 rtl/display_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 8-digit seven-segment scan controller:
// state encoding, digit count and the hex glyph table.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;
  localparam int NIBBLE_W   = 4;
  localparam int SEG_W      = 7;

  // Segment order {g,f,e,d,c,b,a}; entry n is the glyph for hex value n.
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [NUM_DIGITS-1:0] digit_select(input logic [IDX_W-1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit-write bus, scan controls and display drive outputs of the scan controller.
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;

  logic                  n_en;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [NIBBLE_W-1:0]   wr_data;
  logic                  lzb;
  logic [NUM_DIGITS-1:0] ds;
  logic [SEG_W-1:0]      led;
  logic                  frame_done;

  modport master (
    output n_en, wr_en, wr_addr, wr_data, lzb,
    input  ds, led, frame_done
  );

  modport slave (
    input  n_en, wr_en, wr_addr, wr_data, lzb,
    output ds, led, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-high segments {g,f,e,d,c,b,a}.
module seg7_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] digit,
  output logic [SEG_W-1:0]    seg
);

  assign seg = SEG_GLYPHS[digit];

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed display scanner: digit register file, IDLE/BLANK/SHOW
// slot sequencer, leading-zero blanking and fully registered display outputs.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 62500,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk_50mhz,
  input  logic              n_rst,
  display_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [1:0] rst_sync_q;
  logic       run_ok;

  scan_state_t      state_q, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             wrap;

  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] digits_q, digits_nxt;

  logic [SEG_W-1:0]      glyph;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] ds_d;
  logic [SEG_W-1:0]      led_d;

  logic [NUM_DIGITS-1:0] ds_p0;
  logic [SEG_W-1:0]      led_p0;
  logic                  frame_done_p0;

  // Reset asserts asynchronously but releases through two flops, so the
  // sequencer never moves on the edge that sees n_rst rise.
  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_ok = rst_sync_q[1];

  // Write-through view of the register file: outputs are built from it so a
  // digit written on this edge is visible in the very next displayed cycle.
  always_comb begin
    digits_nxt = digits_q;
    if (bus.wr_en) digits_nxt[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) digits_q <= '0;
    else        digits_q <= digits_nxt;
  end

  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    wrap      = 1'b0;
    if (run_ok) begin
      if (bus.n_en) begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_nxt = ST_BLANK;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end
          ST_BLANK: begin
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == BLANK_LAST) state_nxt = ST_SHOW;
          end
          ST_SHOW: begin
            if (cnt_q == CNT_LAST) begin
              cnt_nxt   = '0;
              idx_nxt   = idx_q + IDX_W'(1);
              state_nxt = ST_BLANK;
              wrap      = (idx_q == IDX_LAST);
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  seg7_decode u_seg7_decode (
    .digit (digits_nxt[idx_nxt]),
    .seg   (glyph)
  );

  // Leading zero: this digit and every digit to its left hold 0; digit 0 is exempt.
  always_comb begin
    lz_blank = bus.lzb && (idx_nxt != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_nxt)) && (digits_nxt[j] != '0)) lz_blank = 1'b0;
    end
  end

  always_comb begin
    ds_d  = '0;
    led_d = '0;
    if (state_nxt == ST_SHOW) begin
      ds_d  = digit_select(idx_nxt);
      led_d = lz_blank ? '0 : glyph;
    end
  end

  // Output stage: registered copies aligned with the state register.
  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      ds_p0         <= '0;
      led_p0        <= '0;
      frame_done_p0 <= 1'b0;
    end else begin
      ds_p0         <= ds_d;
      led_p0        <= led_d;
      frame_done_p0 <= wrap;
    end
  end

  assign bus.ds         = ds_p0;
  assign bus.led        = led_p0;
  assign bus.frame_done = frame_done_p0;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a time-indexed scan model.
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = SD * 8;

  logic clk = 1'b0;
  logic n_rst;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_50mhz (clk),
    .n_rst     (n_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] md [8];
  logic       m_lzb;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Expected {frame_done, ds, led} t cycles after the enabling edge.
  function automatic logic [15:0] model_out(input int t);
    int pos, d;
    logic blank;
    logic [15:0] r;
    pos = t % SD;
    d   = (t / SD) % 8;
    r   = '0;
    if (t > 0 && (t % FRAME) == 0) r[15] = 1'b1;
    if (pos >= BC) begin
      blank = m_lzb && (d > 0);
      for (int j = d; j < 8; j++) if (md[j] != 4'h0) blank = 1'b0;
      r[14:7] = 8'(1 << d);
      r[6:0]  = blank ? 7'h00 : ref_glyph(md[d]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_digit(input int a, input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    md[a] = d;
  endtask

  task automatic go_idle();
    bus.n_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] got;
    n_rst = 1'b0;
    bus.n_en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.lzb = 1'b0;
    m_lzb = 1'b0;
    for (int i = 0; i < 8; i++) md[i] = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0000", i, got);
      end
    end
    bus.n_en = 1'b1;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d got=%h exp=0000", i, got);
      end
    end
  endtask

  task automatic test_scan_frame();
    logic [15:0] got, exp;
    go_idle();
    bus.lzb = 1'b0; m_lzb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_digit(i, 4'(i + 1));
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL idle_write i=%0d got=%h exp=0000", i, got);
      end
    end
    bus.n_en = 1'b0;
    for (int t = 0; t < 2 * FRAME + 4; t++) begin
      tick();
      exp = model_out(t);
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL scan_frame t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_live_write();
    logic [15:0] got, exp;
    go_idle();
    bus.n_en = 1'b0;
    for (int t = 0; t < 200; t++) begin
      bus.wr_en = 1'b0;
      if (t == 3 * SD + 4) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 4'hA;
      end else if ($urandom_range(3) == 0) begin
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'($urandom_range(7));
        bus.wr_data = 4'($urandom_range(15));
      end
      if (t != 3 * SD + 4 && $urandom_range(15) == 0) bus.lzb = ~bus.lzb;
      tick();
      if (bus.wr_en) md[bus.wr_addr] = bus.wr_data;
      m_lzb = bus.lzb;
      exp = model_out(t);
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL live_write t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == 3 * SD + 4) begin
        n_vec++;
        if ({bus.ds, bus.led} !== {8'h08, 7'b1110111}) begin
          n_err++;
          $display("FAIL live_write_digit3 ds=%h led=%b exp ds=08 led=1110111", bus.ds, bus.led);
        end
      end
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_lzb();
    logic [15:0] got, exp;
    go_idle();
    for (int i = 0; i < 8; i++) wr_digit(i, 4'h0);
    wr_digit(4, 4'h4);
    bus.lzb = 1'b1; m_lzb = 1'b1;
    bus.n_en = 1'b0;
    for (int t = 0; t < FRAME + 2; t++) begin
      tick();
      exp = model_out(t);
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL lzb t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == BC) begin
        n_vec++;
        if (bus.led !== 7'b0111111) begin
          n_err++;
          $display("FAIL lzb_digit0 led=%b exp=0111111", bus.led);
        end
      end
      if (t == 7 * SD + BC) begin
        n_vec++;
        if ({bus.ds, bus.led} !== {8'h80, 7'h00}) begin
          n_err++;
          $display("FAIL lzb_digit7 ds=%h led=%b exp ds=80 led=0000000", bus.ds, bus.led);
        end
      end
    end
    bus.lzb = 1'b0; m_lzb = 1'b0;
  endtask

  task automatic test_disable();
    logic [15:0] got, exp;
    go_idle();
    for (int i = 0; i < 8; i++) wr_digit(i, 4'($urandom_range(15)));
    bus.n_en = 1'b0;
    for (int t = 0; t <= 5 * SD + 3; t++) begin
      tick();
      exp = model_out(t);
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL disable_pre t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    bus.n_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL disable_off cyc=%0d got=%h exp=0000", i, got);
      end
    end
    bus.n_en = 1'b0;
    for (int t = 0; t < 2 * SD + 4; t++) begin
      tick();
      exp = model_out(t);
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL disable_restart t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got, exp;
    int start;
    bit found;
    go_idle();
    for (int i = 0; i < 8; i++) wr_digit(i, 4'($urandom_range(1, 15)));
    bus.n_en = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    #3;
    n_rst = 1'b0;
    #1;
    got = {bus.frame_done, bus.ds, bus.led};
    n_vec++;
    if (got !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset got=%h exp=0000", got);
    end
    for (int i = 0; i < 8; i++) md[i] = 4'h0;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.frame_done, bus.ds, bus.led};
      n_vec++;
      if (got !== 16'h0) begin
        n_err++;
        $display("FAIL reset_release_early cyc=%0d got=%h exp=0000", i, got);
      end
    end
    found = 1'b0;
    start = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.ds != 8'h00) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_restart_timeout ds=%h exp=01 within 20 cycles", bus.ds);
    end else begin
      exp = model_out(BC);
      got = {bus.frame_done, bus.ds, bus.led};
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_first_show got=%h exp=%h", got, exp);
      end
      start = BC + 1;
      for (int t = start; t < FRAME + 4; t++) begin
        tick();
        exp = model_out(t);
        got = {bus.frame_done, bus.ds, bus.led};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL reset_readback t=%0d got=%h exp=%h", t, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_live_write();
    test_lzb();
    test_disable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
